// File: rtl/spi_frame_rx.sv
// SPI frame receiver: synchronises sck/cs/sdi into clk, assembles MSB-first
// frames of FRAME_BYTES bytes and queues them in a small frame FIFO.
module spi_frame_rx #(
  parameter int unsigned FRAME_BYTES = 3,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SCK_EDGE    = 0
) (
  input  logic                             clk,
  input  logic                             resetB,
  input  logic                             sck,
  input  logic                             cs,
  input  logic                             sdi,
  output logic [FRAME_BYTES*8-1:0]         frame_data,
  output logic                             frame_valid,
  input  logic                             frame_ready,
  output logic [$clog2(DEPTH+1)-1:0]       fifo_count,
  output logic                             overflow,
  output logic                             short_frame
);

  localparam int unsigned FW  = FRAME_BYTES * 8;
  localparam int unsigned BCW = $clog2(FW);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned NW  = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, sdi_sync_q;
  logic                   sck_s, cs_s, sdi_s;
  logic                   sck_last_q, cs_last_q;
  logic                   sck_edge_c;

  state_t                 state_q, state_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]          shift_q, shift_d;
  logic                   push_q, push_d;
  logic                   short_q, short_d;

  logic [FW-1:0]          mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]          count_q, count_d;
  logic                   valid_q, valid_d;
  logic [FW-1:0]          data_q, data_d;
  logic                   ovf_q, ovf_d;
  logic                   pop_c, full_c, accept_c;
  logic [FW-1:0]          head_c;

  // Synchronisers for the asynchronous SPI pins (intentionally not reset)
  always_ff @(posedge clk) begin
    sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
    sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
  end

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  assign sck_edge_c = (SCK_EDGE == 0) ? (sck_s & ~sck_last_q) : (~sck_s & sck_last_q);

  // Receive FSM: cs framing, bit counting and shift-register assembly
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    short_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // cs_last_q resets high so a cs held across reset is not a new frame
        if (cs_s && !cs_last_q) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end
      end
      RECV: begin
        if (!cs_s) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          short_d   = (bit_cnt_q != '0);
        end else if (sck_edge_c) begin
          shift_d = {shift_q[FW-2:0], sdi_s};
          if (bit_cnt_q == BCW'(FW - 1)) begin
            bit_cnt_d = '0;
            push_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO control; head data is precomputed so frame_data is registered
  always_comb begin
    pop_c    = valid_q & frame_ready;
    full_c   = (count_q == NW'(DEPTH));
    accept_c = push_q & (~full_c | pop_c);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (accept_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)    rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_q && full_c && !pop_c) ovf_d = 1'b1;
    case ({accept_c, pop_c})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
    // Frame being written this cycle becomes head when it lands at the new read slot
    head_c  = (accept_c && (rd_ptr_d == wr_ptr_q)) ? shift_q : mem_q[rd_ptr_d];
    valid_d = (count_d != '0);
    data_d  = valid_d ? head_c : '0;
  end

  // Frame storage (contents are don't-care while not counted)
  always_ff @(posedge clk) begin
    if (accept_c) mem_q[wr_ptr_q] <= shift_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetB) begin
      sck_last_q <= 1'b0;
      cs_last_q  <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      short_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sck_last_q <= sck_s;
      cs_last_q  <= cs_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
      short_q    <= short_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;
  assign short_frame = short_q;

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 Parameter FRAME_BYTES, default 3: bytes per SPI frame (1..8).
REQ-002 Parameter DEPTH, default 4: frame FIFO entries (power of 2, ≥2).
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flops on sck, cs and sdi (≥2).
REQ-004 Parameter SCK_EDGE, default 0: 0 samples sdi on sck rising edge, 1 on falling edge.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 resetB  input  1  synchronous, active-low reset.
REQ-007 sck  input  1  SPI clock, asynchronous to clk.
REQ-008 cs  input  1  frame enable, active-high, asynchronous.
REQ-009 sdi  input  1  serial data, MSB first, asynchronous.
REQ-010 frame_data  output  FRAME_BYTES*8  FIFO head frame; first received byte in the top 8 bits.
REQ-011 frame_valid  output  1  FIFO non-empty.
REQ-012 frame_ready  input  1  consumer accepts head frame.
REQ-013 fifo_count  output  $clog2(DEPTH+1)  occupied entries.
REQ-014 overflow  output  1  sticky; a complete frame was dropped.
REQ-015 short_frame  output  1  one-cycle pulse; a partial frame was discarded.

Function
REQ-016 sck, cs and sdi SHALL each pass through SYNC_STAGES flops before use; sck edge detection SHALL use the last two synchronised sck samples.
REQ-017 Receive FSM states SHALL be IDLE (synchronised cs low) and RECV (synchronised cs high); IDLE->RECV on cs rise with bit counter cleared; RECV->IDLE on cs fall.
REQ-018 In RECV, each detected sck edge of polarity SCK_EDGE SHALL shift synchronised sdi into the LSB of the shift register and increment the bit counter.
REQ-019 When the counter reaches FRAME_BYTES*8, it SHALL wrap to 0 and the assembled frame SHALL be pushed into the FIFO on the next clk edge; further bits under the same cs SHALL start a new frame (back-to-back streaming).
REQ-020 cs fall with bit counter ≠ 0 SHALL discard the partial frame, clear the counter and assert short_frame for exactly one cycle; cs fall with counter = 0 SHALL produce no pulse.
REQ-021 Pop SHALL occur when frame_valid & frame_ready; frame_data SHALL update to the next entry on the following cycle.
REQ-022 frame_data SHALL be all-zero whenever frame_valid is 0.
REQ-023 Push while full and no pop in that cycle SHALL drop the new frame, leave FIFO contents unchanged and set overflow; overflow clears only on reset.
REQ-024 Push and pop in the same cycle while full SHALL accept the push, keep fifo_count = DEPTH and leave overflow unchanged.
REQ-025 Push into empty FIFO SHALL raise frame_valid on the following cycle; pop and push in the same cycle SHALL leave fifo_count unchanged.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH or underflow.
REQ-027 Correct capture is required only when sck high and low phases each last ≥ SYNC_STAGES+2 clk cycles.

Reset
REQ-028 While resetB is 0 at a clk edge: FSM->IDLE, bit counter, shift register and pointers->0, fifo_count=0, frame_valid=0, frame_data=0, overflow=0, short_frame=0.
REQ-029 Reset mid-frame SHALL discard the partial frame and all FIFO contents; after release, reception SHALL restart only on a new cs rise.
REQ-030 Synchroniser flops need not be reset.

Verification
REQ-031 Defaults, one cs burst sending 0xA5 0x3C 0x81, frame_ready=0 -> frame_valid=1, frame_data=0xA53C81, fifo_count=1, no short_frame.
REQ-032 Six back-to-back frames in one cs burst, frame_ready=0, DEPTH=4 -> fifo_count=4, overflow=1, first four frames delivered in order once frame_ready=1.
REQ-033 cs dropped after 13 bits -> short_frame high exactly 1 cycle, fifo_count unchanged; next full frame received correctly.
REQ-034 FIFO full, frame_ready=1 held while a new frame completes -> push accepted in pop cycle, fifo_count stays 4, overflow remains 0.
REQ-035 resetB low for one cycle midway through the second byte with two frames queued -> all outputs at reset values; subsequent cs burst 0x01 0x02 0x03 yields frame_data=0x010203.
REQ-036 SCK_EDGE=1, FRAME_BYTES=2, frame 0xBEEF -> frame_data=0xBEEF.
